// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Down-counting mm:ss timer. A controller loads a duration, starts, pauses
//   and resumes it. A one-cycle `done` pulse marks expiry at 00:00.
//
// Parameters
//   TICK_DIV : clk cycles per one-second decrement (1..1024, 1 = every cycle)
//
// Ports
//   clk       in   clock, all logic on posedge
//   reset     in   synchronous, active-high
//   load      in   single-cycle request to load load_min:load_sec
//   load_min  in   [5:0] minutes to load (legal 0..59)
//   load_sec  in   [5:0] seconds to load (legal 0..59)
//   start     in   level-sampled start / resume request
//   pause     in   level-sampled pause request
//   minutes   out  [5:0] current minutes
//   seconds   out  [5:0] current seconds
//   running   out  high while counting
//   done      out  one-cycle pulse on reaching 00:00 while counting
//   load_err  out  one-cycle pulse when a load is rejected
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       running,
  output logic       done,
  output logic       load_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RUN     = 2'd1;
  localparam logic [1:0] S_PAUSED  = 2'd2;
  localparam logic [1:0] S_EXPIRED = 2'd3;

  // Prescaler needs at least one bit even when TICK_DIV == 1.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [1:0]    state_q, state_d;
  logic [5:0]    minutes_q, minutes_d;
  logic [5:0]    seconds_q, seconds_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          running_q, running_d;
  logic          done_q, done_d;
  logic          load_err_q, load_err_d;

  // Decrement helpers, used only when a tick is taken.
  logic          tick;
  logic [PW-1:0] pre_adv;
  logic [5:0]    dec_min;
  logic [5:0]    dec_sec;
  logic          dec_zero;
  logic          load_ok;
  logic          count_nz;
  logic          advance;

  always_comb begin
    tick     = (pre_q == PRE_LAST);
    pre_adv  = tick ? '0 : pre_q + PW'(1);
    if (seconds_q != 6'd0) begin
      dec_sec = seconds_q - 6'd1;
      dec_min = minutes_q;
    end else begin
      dec_sec = 6'd59;
      dec_min = minutes_q - 6'd1;
    end
    // The only way a decrement lands on 00:00 is from 00:01.
    dec_zero = (minutes_q == 6'd0) && (seconds_q == 6'd1);
    load_ok  = (load_min <= 6'd59) && (load_sec <= 6'd59);
    count_nz = (minutes_q != 6'd0) || (seconds_q != 6'd0);
  end

  always_comb begin
    state_d    = state_q;
    minutes_d  = minutes_q;
    seconds_d  = seconds_q;
    pre_d      = pre_q;
    done_d     = 1'b0;
    load_err_d = 1'b0;
    advance    = 1'b0;

    if (load && (state_q != S_RUN)) begin
      // Any load outside RUN consumes the cycle, legal or not.
      if (load_ok) begin
        minutes_d = load_min;
        seconds_d = load_sec;
        state_d   = S_IDLE;
        pre_d     = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (state_q == S_RUN) begin
      // A load in RUN is transparent; pause freezes counters and prescaler.
      if (pause) begin
        state_d = S_PAUSED;
      end else begin
        advance = 1'b1;
      end
    end else if (start && count_nz &&
                 ((state_q == S_IDLE) || (state_q == S_PAUSED))) begin
      state_d = S_RUN;
      // The resume cycle itself counts toward the partial second that the
      // pause interrupted; a fresh start from IDLE begins a whole second.
      advance = (state_q == S_PAUSED);
    end

    if (advance) begin
      pre_d = pre_adv;
      if (tick) begin
        minutes_d = dec_min;
        seconds_d = dec_sec;
        if (dec_zero) begin
          state_d = S_EXPIRED;
          done_d  = 1'b1;
        end
      end
    end

    running_d = (state_d == S_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      minutes_q  <= 6'd0;
      seconds_q  <= 6'd0;
      pre_q      <= '0;
      running_q  <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      pre_q      <= pre_d;
      running_q  <= running_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
    end
  end

  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign running  = running_q;
  assign done     = done_q;
  assign load_err = load_err_q;

  a_range : assert property (@(posedge clk) disable iff (reset)
    (minutes_q <= 6'd59) && (seconds_q <= 6'd59));
  a_done_pulse : assert property (@(posedge clk) disable iff (reset)
    done_q |=> !done_q);
  a_running : assert property (@(posedge clk) disable iff (reset)
    running_q == (state_q == S_RUN));

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Drives two timers (TICK_DIV = 1 and TICK_DIV = 4) from shared inputs.
//   Each is compared every cycle with a total-seconds reference model, and
//   directed sequences check the documented corner cases with fixed values.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int M_IDLE    = 10;
  localparam int M_RUN     = 11;
  localparam int M_PAUSED  = 12;
  localparam int M_EXPIRED = 13;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [5:0] load_min = 6'd0;
  logic [5:0] load_sec = 6'd0;

  logic [5:0] min1, sec1, min4, sec4;
  logic       run1, done1, err1, run4, done4, err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer #(.TICK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause),
    .minutes(min1), .seconds(sec1), .running(run1), .done(done1),
    .load_err(err1)
  );

  countdown_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .load(load), .load_min(load_min),
    .load_sec(load_sec), .start(start), .pause(pause),
    .minutes(min4), .seconds(sec4), .running(run4), .done(done4),
    .load_err(err4)
  );

  // Reference model: remaining time as total seconds, plus elapsed running
  // cycles within the current second.
  typedef struct {
    int st;
    int total;
    int phase;
    bit done;
    bit err;
  } model_t;

  model_t m1, m4;

  function automatic model_t mstep(model_t m, int td, bit rs, bit ld,
                                   int lm, int ls, bit st, bit pa);
    model_t n;
    bit adv;
    n = m;
    adv = 1'b0;
    n.done = 1'b0;
    n.err = 1'b0;
    if (rs) begin
      n.st = M_IDLE; n.total = 0; n.phase = 0;
    end else if (ld && m.st != M_RUN) begin
      if (lm < 60 && ls < 60) begin
        n.total = lm * 60 + ls; n.st = M_IDLE; n.phase = 0;
      end else begin
        n.err = 1'b1;
      end
    end else if (m.st == M_RUN) begin
      if (pa) n.st = M_PAUSED;
      else adv = 1'b1;
    end else if (st && (m.st == M_IDLE || m.st == M_PAUSED) && m.total > 0) begin
      n.st = M_RUN;
      adv = (m.st == M_PAUSED);
    end
    if (adv) begin
      n.phase = m.phase + 1;
      if (n.phase == td) begin
        n.phase = 0;
        n.total = m.total - 1;
        if (n.total == 0) begin
          n.st = M_EXPIRED;
          n.done = 1'b1;
        end
      end
    end
    return n;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp_model(input string tag, input model_t m, input logic [5:0] mi,
                           input logic [5:0] se, input logic ru, input logic dn,
                           input logic er);
    logic [14:0] e, a;
    e = {6'(m.total / 60), 6'(m.total % 60), (m.st == M_RUN), m.done, m.err};
    a = {mi, se, ru, dn, er};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d:%0d run=%0b done=%0b err=%0b expected %0d:%0d run=%0b done=%0b err=%0b",
               tag, mi, se, ru, dn, er, e[14:9], e[8:3], e[2], e[1], e[0]);
    end
  endtask

  // One clock: drive inputs, take the edge, advance both models, compare.
  task automatic cycle(input bit rs, input bit ld, input int lm, input int ls,
                       input bit st, input bit pa);
    reset = rs; load = ld; load_min = 6'(lm); load_sec = 6'(ls);
    start = st; pause = pa;
    @(posedge clk);
    m1 = mstep(m1, 1, rs, ld, lm, ls, st, pa);
    m4 = mstep(m4, 4, rs, ld, lm, ls, st, pa);
    #1;
    cmp_model("model_td1", m1, min1, sec1, run1, done1, err1);
    cmp_model("model_td4", m4, min4, sec4, run4, done4, err4);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit ld; int lm; int ls; bit st; bit pa;
    int emin; int esec; bit erun; bit edone; bit eerr;
  } vec_t;

  vec_t vec[17];

  initial begin
    int ndone;
    int ntick;
    bit rs, ld, st, pa;
    int lm, ls;

    // TICK_DIV = 1 vectors: inputs before the edge, outputs after it.
    vec[0]  = '{1, 0, 3,  0, 0,  0, 3, 0, 0, 0};  // load 00:03
    vec[1]  = '{0, 0, 0,  1, 0,  0, 3, 1, 0, 0};  // start
    vec[2]  = '{0, 0, 0,  0, 0,  0, 2, 1, 0, 0};
    vec[3]  = '{0, 0, 0,  0, 0,  0, 1, 1, 0, 0};
    vec[4]  = '{0, 0, 0,  0, 0,  0, 0, 0, 1, 0};  // expiry
    vec[5]  = '{0, 0, 0,  0, 0,  0, 0, 0, 0, 0};
    vec[6]  = '{0, 0, 0,  1, 0,  0, 0, 0, 0, 0};  // start in EXPIRED ignored
    vec[7]  = '{1, 0, 60, 0, 0,  0, 0, 0, 0, 1};  // 00:60 rejected
    vec[8]  = '{1, 60, 0, 0, 0,  0, 0, 0, 0, 1};  // 60:00 rejected
    vec[9]  = '{1, 0, 5,  0, 0,  0, 5, 0, 0, 0};  // 00:05 leaves EXPIRED
    vec[10] = '{1, 0, 0,  0, 0,  0, 0, 0, 0, 0};  // 00:00 is legal
    vec[11] = '{0, 0, 0,  1, 0,  0, 0, 0, 0, 0};  // start at 00:00 ignored
    vec[12] = '{1, 0, 2,  0, 0,  0, 2, 0, 0, 0};
    vec[13] = '{0, 0, 0,  1, 0,  0, 2, 1, 0, 0};
    vec[14] = '{1, 10, 10, 0, 0, 0, 1, 1, 0, 0};  // load in RUN ignored
    vec[15] = '{0, 0, 0,  1, 1,  0, 1, 0, 0, 0};  // start+pause in RUN: pause
    vec[16] = '{0, 0, 0,  1, 1,  0, 0, 0, 1, 0};  // start+pause in PAUSED: resume

    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    check("reset_min", min1, 0);
    check("reset_sec", sec1, 0);
    check("reset_flags", {run1, done1, err1}, 0);

    for (int i = 0; i < 17; i++) begin
      cycle(0, vec[i].ld, vec[i].lm, vec[i].ls, vec[i].st, vec[i].pa);
      $display("vec %0d: ld=%0b %0d:%0d st=%0b pa=%0b -> %0d:%0d run=%0b done=%0b err=%0b",
               i, vec[i].ld, vec[i].lm, vec[i].ls, vec[i].st, vec[i].pa,
               min1, sec1, run1, done1, err1);
      check($sformatf("vec%0d_min", i), min1, vec[i].emin);
      check($sformatf("vec%0d_sec", i), sec1, vec[i].esec);
      check($sformatf("vec%0d_running", i), run1, vec[i].erun);
      check($sformatf("vec%0d_done", i), done1, vec[i].edone);
      check($sformatf("vec%0d_load_err", i), err1, vec[i].eerr);
    end

    // Minute borrow: 01:00 takes exactly 60 ticks with one done pulse.
    cycle(0, 1, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    ndone = 0;
    ntick = 0;
    for (int t = 1; t <= 60; t++) begin
      idle(1);
      ntick++;
      if (done1) ndone++;
      if (t == 1) begin
        check("borrow_first_min", min1, 0);
        check("borrow_first_sec", sec1, 59);
      end
    end
    $display("borrow: %0d ticks, %0d done pulses, now %0d:%0d", ntick, ndone, min1, sec1);
    check("borrow_done_last", done1, 1);
    check("borrow_done_count", ndone, 1);
    idle(1);
    check("borrow_done_cleared", done1, 0);

    // Pause and resume on the TICK_DIV = 4 timer.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 2, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);            // edge 0: start
    idle(1);                            // edge 1
    cycle(0, 0, 0, 0, 0, 1);            // edge 2: pause
    check("pause_running", run4, 0);
    check("pause_sec", sec4, 2);
    idle(3);                            // edges 3..5
    cycle(0, 0, 0, 0, 1, 0);            // edge 6: resume
    check("resume_running", run4, 1);
    idle(1);                            // edge 7
    check("resume_sec_e7", sec4, 2);
    idle(1);                            // edge 8
    check("resume_sec_e8", sec4, 1);
    idle(3);                            // edges 9..11
    check("resume_done_e11", done4, 0);
    idle(1);                            // edge 12
    $display("pause/resume td4: %0d:%0d run=%0b done=%0b", min4, sec4, run4, done4);
    check("resume_done_e12", done4, 1);
    check("resume_sec_e12", sec4, 0);

    // Reset mid-run, with an illegal load in the reset cycle.
    cycle(0, 1, 59, 59, 0, 0);
    cycle(0, 0, 0, 0, 1, 0);
    idle(10);
    check("midrun_min", min1, 59);
    check("midrun_sec", sec1, 49);
    cycle(1, 1, 0, 60, 0, 0);
    $display("reset mid-run: %0d:%0d run=%0b done=%0b err=%0b", min1, sec1, run1, done1, err1);
    check("midrun_reset_time", {min1, sec1}, 0);
    check("midrun_reset_flags", {run1, done1, err1, run4, done4, err4}, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rs = ($urandom_range(0, 99) == 0);
      ld = ($urandom_range(0, 9) == 0);
      lm = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 1));
      ls = int'($urandom_range(0, 63));
      st = ($urandom_range(0, 2) == 0);
      pa = ($urandom_range(0, 9) == 0);
      cycle(rs, ld, lm, ls, st, pa);
      $display("rnd %0d: rs=%0b ld=%0b %0d:%0d st=%0b pa=%0b | td1 %0d:%0d r%0b d%0b e%0b | td4 %0d:%0d r%0b d%0b e%0b",
               i, rs, ld, lm, ls, st, pa, min1, sec1, run1, done1, err1,
               min4, sec4, run4, done4, err4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
